// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/sub/accumulate/load unit with a two-stage valid/ready output
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   a, b       in   [WIDTH-1:0] unsigned operands
//   mode       in   [1:0] 00 add, 01 sub, 10 accumulate, 11 load accumulator
//   out_valid  out  result beat valid
//   out_ready  in   consumer takes the result
//   y          out  [WIDTH+ACC_EXT-1:0] result
//   flag       out  carry (add), borrow (sub) or overflow (accumulate) of this result
//   acc_ovf    out  sticky accumulator overflow, cleared by reset or an accepted load
module adder_pipe #(
    parameter int WIDTH   = 4,
    parameter int ACC_EXT = 4,
    parameter bit SAT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+ACC_EXT-1:0] y,
    output logic                     flag,
    output logic                     acc_ovf
);
    localparam int ACC_W = WIDTH + ACC_EXT;
    localparam logic [1:0] M_SUB  = 2'b01;
    localparam logic [1:0] M_ACC  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic             s1_valid_q, s2_valid_q;
    logic [ACC_W-1:0] s1_y_q, s1_y_d, y_q, acc_q, acc_d;
    logic             s1_flag_q, s1_flag_d, flag_q, acc_ovf_q, acc_ovf_d;
    logic             s1_adv, s2_adv, accept;
    logic [WIDTH:0]   sum, diff;
    logic [ACC_W:0]   acc_next;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    assign sum      = {1'b0, a} + {1'b0, b};
    // WIDTH+1-bit two's complement difference; its top bit is the borrow
    assign diff     = {1'b0, a} - {1'b0, b};
    assign acc_next = {1'b0, acc_q} + (ACC_W+1)'(a) + (ACC_W+1)'(b);

    always_comb begin
        s1_y_d    = ACC_W'(sum);
        s1_flag_d = sum[WIDTH];
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        case (mode)
            M_SUB: begin
                s1_y_d    = ACC_W'($signed(diff));
                s1_flag_d = diff[WIDTH];
            end
            M_ACC: begin
                acc_d     = (acc_next[ACC_W] && SAT) ? '1 : acc_next[ACC_W-1:0];
                acc_ovf_d = acc_ovf_q || acc_next[ACC_W];
                s1_y_d    = acc_d;
                s1_flag_d = acc_next[ACC_W];
            end
            M_LOAD: begin
                acc_d     = ACC_W'(sum);
                acc_ovf_d = 1'b0;
                s1_y_d    = acc_d;
                s1_flag_d = 1'b0;
            end
            default: ;
        endcase
    end

    // acc moves on the accept edge so chained acc/load beats see each other without stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_flag_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            flag_q     <= 1'b0;
        end else begin
            if (accept) begin
                acc_q     <= acc_d;
                acc_ovf_q <= acc_ovf_d;
            end
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (accept) begin
                    s1_y_q    <= s1_y_d;
                    s1_flag_q <= s1_flag_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q    <= s1_y_q;
                    flag_q <= s1_flag_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign flag      = flag_q;
    assign acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: checks adder_pipe (SAT=0 and SAT=1 side by side) against an arithmetic reference model
module tb_adder_pipe;
    localparam int W    = 4;
    localparam int AW   = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam int MAXA = (1 << AW) - 1;

    typedef struct packed {
        logic [AW-1:0] y;
        logic          f;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready0, in_ready1, out_valid0, out_valid1, flag0, flag1, acc_ovf0, acc_ovf1;
    logic [AW-1:0] y0, y1;

    int tests = 0, fails = 0;
    exp_t q0[$], q1[$];
    int m_acc[2] = '{0, 0};
    bit m_ovf[2] = '{0, 0};

    bit o_acc, o_emit, o_qerr, o_ov, o_sync, o_ovf0, o_ovf1;
    logic [AW-1:0] o_y0, o_y1;
    logic o_f0, o_f1;
    exp_t o_e0, o_e1;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .ACC_EXT(AW - W), .SAT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
        .mode(mode), .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .flag(flag0),
        .acc_ovf(acc_ovf0)
    );

    adder_pipe #(.WIDTH(W), .ACC_EXT(AW - W), .SAT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .mode(mode), .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .flag(flag1),
        .acc_ovf(acc_ovf1)
    );

    function automatic exp_t model(input int s, input logic [1:0] md, input int x, input int z);
        exp_t e;
        int n;
        e = '0;
        case (md)
            2'd0: begin
                n = x + z;
                e.y = AW'(n);
                e.f = (n > MAXV);
            end
            2'd1: begin
                e.y = AW'((x - z) & MAXA);
                e.f = (x < z);
            end
            2'd2: begin
                n = m_acc[s] + x + z;
                e.f = (n > MAXA);
                if (e.f) begin
                    m_ovf[s] = 1'b1;
                    m_acc[s] = (s == 1) ? MAXA : n - (MAXA + 1);
                end else m_acc[s] = n;
                e.y = AW'(m_acc[s]);
            end
            default: begin
                m_acc[s] = x + z;
                m_ovf[s] = 1'b0;
                e.y = AW'(m_acc[s]);
                e.f = 1'b0;
            end
        endcase
        return e;
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        m_acc = '{0, 0};
        m_ovf = '{0, 0};
    endfunction

    // one clock: drive, observe at the falling edge, update the model, return 1ns after the rising edge
    task automatic tick(input bit v, input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] z, input bit ordy);
        in_valid = v;
        mode = md;
        a = x;
        b = z;
        out_ready = ordy;
        @(negedge clk);
        o_acc  = in_valid && in_ready0;
        o_emit = out_valid0 && out_ready;
        o_ov   = out_valid0;
        o_sync = (in_ready0 === in_ready1) && (out_valid0 === out_valid1);
        o_y0 = y0; o_f0 = flag0; o_y1 = y1; o_f1 = flag1;
        o_ovf0 = acc_ovf0; o_ovf1 = acc_ovf1;
        o_qerr = 1'b0; o_e0 = '0; o_e1 = '0;
        if (o_emit) begin
            if (q0.size() == 0 || q1.size() == 0) o_qerr = 1'b1;
            else begin
                o_e0 = q0.pop_front();
                o_e1 = q1.pop_front();
            end
        end
        if (o_acc) begin
            q0.push_back(model(0, md, int'(x), int'(z)));
            q1.push_back(model(1, md, int'(x), int'(z)));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid0 !== 1'b0 || y0 !== '0 || flag0 !== 1'b0 || acc_ovf0 !== 1'b0)
            begin fails++; $display("FAIL reset_hold_sat0: out_valid=%b y=%0d flag=%b acc_ovf=%b, want all 0", out_valid0, y0, flag0, acc_ovf0); end
        tests++;
        if (out_valid1 !== 1'b0 || y1 !== '0 || flag1 !== 1'b0 || acc_ovf1 !== 1'b0)
            begin fails++; $display("FAIL reset_hold_sat1: out_valid=%b y=%0d flag=%b acc_ovf=%b, want all 0", out_valid1, y1, flag1, acc_ovf1); end
        reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1)
            begin fails++; $display("FAIL reset_in_ready: %b/%b, want 1/1", in_ready0, in_ready1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        tick(1, 2'd0, 4'd9, 4'd8, 1);
        tests++; if (o_emit !== 1'b0) begin fails++; $display("FAIL add_latency0: emit=%b want 0", o_emit); end
        tick(1, 2'd0, 4'd3, 4'd4, 1);
        tests++; if (o_emit !== 1'b0) begin fails++; $display("FAIL add_latency1: emit=%b want 0", o_emit); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++;
        if (o_emit !== 1'b1 || o_qerr || {o_y0, o_f0, o_y1, o_f1} !== {8'd17, 1'b1, 8'd17, 1'b1} || {o_y0, o_f0} !== o_e0)
            begin fails++; $display("FAIL add_9_8: emit=%b y=%0d/%0d flag=%b/%b, want y=17 flag=1", o_emit, o_y0, o_y1, o_f0, o_f1); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++;
        if (o_emit !== 1'b1 || o_qerr || {o_y0, o_f0, o_y1, o_f1} !== {8'd7, 1'b0, 8'd7, 1'b0} || {o_y0, o_f0} !== o_e0)
            begin fails++; $display("FAIL add_3_4: emit=%b y=%0d/%0d flag=%b/%b, want y=7 flag=0", o_emit, o_y0, o_y1, o_f0, o_f1); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++; if (o_emit !== 1'b0) begin fails++; $display("FAIL add_no_dup: emit=%b want 0", o_emit); end
    endtask

    task automatic test_sub();
        tick(1, 2'd1, 4'd3, 4'd5, 1);
        tick(1, 2'd1, 4'd5, 4'd3, 1);
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++;
        if (o_emit !== 1'b1 || o_qerr || {o_y0, o_f0, o_y1, o_f1} !== {8'hFE, 1'b1, 8'hFE, 1'b1} || {o_y0, o_f0} !== o_e0)
            begin fails++; $display("FAIL sub_3_5: emit=%b y=%h/%h flag=%b/%b, want y=fe flag=1", o_emit, o_y0, o_y1, o_f0, o_f1); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++;
        if (o_emit !== 1'b1 || o_qerr || {o_y0, o_f0, o_y1, o_f1} !== {8'd2, 1'b0, 8'd2, 1'b0} || {o_y0, o_f0} !== o_e0)
            begin fails++; $display("FAIL sub_5_3: emit=%b y=%0d/%0d flag=%b/%b, want y=2 flag=0", o_emit, o_y0, o_y1, o_f0, o_f1); end
    endtask

    task automatic test_accumulate();
        int ey0[11] = '{30, 60, 90, 120, 150, 180, 210, 240, 14, 44, 2};
        int ey1[11] = '{30, 60, 90, 120, 150, 180, 210, 240, 255, 255, 2};
        bit ef0[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        bit ef1[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        int k = 0, n_acc = 0;
        for (int i = 0; i < 24 && k < 11; i++) begin
            if (i < 11) tick(1, (i == 0 || i == 10) ? 2'd3 : 2'd2, (i == 10) ? 4'd1 : 4'd15, (i == 10) ? 4'd1 : 4'd15, 1);
            else tick(0, 2'd0, 4'd0, 4'd0, 1);
            if (i < 11 && o_acc) n_acc++;
            if (o_emit) begin
                tests++;
                if (o_qerr || o_y0 !== AW'(ey0[k]) || o_f0 !== ef0[k] || {o_y0, o_f0} !== o_e0)
                    begin fails++; $display("FAIL acc_sat0[%0d]: y=%0d flag=%b, want y=%0d flag=%b", k, o_y0, o_f0, ey0[k], ef0[k]); end
                tests++;
                if (o_qerr || o_y1 !== AW'(ey1[k]) || o_f1 !== ef1[k] || {o_y1, o_f1} !== o_e1)
                    begin fails++; $display("FAIL acc_sat1[%0d]: y=%0d flag=%b, want y=%0d flag=%b", k, o_y1, o_f1, ey1[k], ef1[k]); end
                if (k == 8 || k == 10) begin
                    tests++;
                    if (o_ovf0 !== (k == 8) || o_ovf1 !== (k == 8))
                        begin fails++; $display("FAIL acc_ovf[%0d]: %b/%b, want %b", k, o_ovf0, o_ovf1, k == 8); end
                end
                k++;
            end
        end
        tests++; if (n_acc != 11) begin fails++; $display("FAIL acc_throughput: accepted %0d, want 11", n_acc); end
        tests++; if (k != 11) begin fails++; $display("FAIL acc_count: emitted %0d, want 11", k); end
    endtask

    task automatic test_stall();
        int got[$];
        bit sent = 1'b0;
        tick(1, 2'd0, 4'd1, 4'd1, 0);
        tests++; if (o_acc !== 1'b1) begin fails++; $display("FAIL stall_acc1: accepted=%b want 1", o_acc); end
        tick(1, 2'd0, 4'd2, 4'd2, 0);
        tests++; if (o_acc !== 1'b1) begin fails++; $display("FAIL stall_acc2: accepted=%b want 1", o_acc); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 2'd0, 4'd3, 4'd3, 0);
            tests++;
            if (o_acc !== 1'b0 || o_ov !== 1'b1 || o_y0 !== 8'd2 || o_y1 !== 8'd2)
                begin fails++; $display("FAIL stall_hold[%0d]: accepted=%b out_valid=%b y=%0d/%0d, want 0 1 2", i, o_acc, o_ov, o_y0, o_y1); end
        end
        tests++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin fails++; $display("FAIL stall_in_ready: %b/%b want 0", in_ready0, in_ready1); end
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            tick(!sent, 2'd0, 4'd3, 4'd3, 1);
            if (o_acc) sent = 1'b1;
            if (o_emit) begin
                got.push_back(int'(o_y0));
                tests++;
                if (o_qerr || {o_y0, o_f0} !== o_e0 || {o_y1, o_f1} !== o_e1)
                    begin fails++; $display("FAIL stall_drain_model: y=%0d/%0d, want %0d/%0d", o_y0, o_y1, o_e0.y, o_e1.y); end
            end
        end
        tests++;
        if (got.size() != 3 || got[0] != 2 || got[1] != 4 || got[2] != 6)
            begin fails++; $display("FAIL stall_order: got %0d beats %p, want 2 4 6", got.size(), got); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++; if (o_emit !== 1'b0) begin fails++; $display("FAIL stall_no_dup: emit=%b want 0", o_emit); end
    endtask

    task automatic test_reset_midflight();
        tick(1, 2'd3, 4'd15, 4'd15, 1);
        for (int i = 0; i < 8; i++) tick(1, 2'd2, 4'd15, 4'd15, 1);
        tick(1, 2'd2, 4'd13, 4'd13, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 2'd0, 4'd0, 4'd0, 1);
            if (o_emit && i == 1) begin
                tests++;
                if (o_qerr || o_y0 !== 8'd40 || o_y1 !== 8'd255 || {o_y0, o_f0} !== o_e0 || {o_y1, o_f1} !== o_e1)
                    begin fails++; $display("FAIL mid_acc40: y=%0d/%0d, want 40/255", o_y0, o_y1); end
            end
        end
        tests++; if (acc_ovf0 !== 1'b1 || q0.size() != 0) begin fails++; $display("FAIL mid_setup: acc_ovf=%b pending=%0d, want 1 0", acc_ovf0, q0.size()); end
        tick(1, 2'd0, 4'd1, 4'd1, 0);
        tick(1, 2'd0, 4'd2, 4'd2, 0);
        in_valid = 1'b0;
        tests++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin fails++; $display("FAIL mid_full: out_valid=%b in_ready=%b, want 1 0", out_valid0, in_ready0); end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (out_valid0 !== 1'b0 || y0 !== '0 || flag0 !== 1'b0 || acc_ovf0 !== 1'b0 || out_valid1 !== 1'b0 || y1 !== '0 || acc_ovf1 !== 1'b0)
            begin fails++; $display("FAIL mid_async_reset: out_valid=%b y=%0d flag=%b acc_ovf=%b/%b, want all 0", out_valid0, y0, flag0, acc_ovf0, acc_ovf1); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL mid_release_ready: in_ready=%b want 1", in_ready0); end
        tick(1, 2'd2, 4'd1, 4'd1, 1);
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++;
        if (o_emit !== 1'b1 || o_qerr || {o_y0, o_f0, o_y1, o_f1} !== {8'd2, 1'b0, 8'd2, 1'b0} || {o_y0, o_f0} !== o_e0)
            begin fails++; $display("FAIL mid_acc_after_reset: emit=%b y=%0d/%0d flag=%b, want y=2 flag=0", o_emit, o_y0, o_y1, o_f0); end
        tick(0, 2'd0, 4'd0, 4'd0, 1);
        tests++; if (o_emit !== 1'b0) begin fails++; $display("FAIL mid_discard: emit=%b want 0", o_emit); end
    endtask

    task automatic test_random();
        bit prev_stall = 1'b0;
        logic [AW-1:0] prev_y = '0;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0, 2'($urandom), W'($urandom), W'($urandom), ($urandom % 3) != 0);
            tests++; if (!o_sync) begin fails++; $display("FAIL rnd_sync[%0d]: handshakes differ between instances", i); end
            if (prev_stall) begin
                tests++;
                if (o_y0 !== prev_y) begin fails++; $display("FAIL rnd_stable[%0d]: y=%0d, want %0d", i, o_y0, prev_y); end
            end
            prev_stall = o_ov && !out_ready;
            prev_y = o_y0;
            if (o_emit) begin
                tests++;
                if (o_qerr || {o_y0, o_f0} !== o_e0) begin fails++; $display("FAIL rnd_sat0[%0d]: y=%0d flag=%b, want y=%0d flag=%b", i, o_y0, o_f0, o_e0.y, o_e0.f); end
                tests++;
                if (o_qerr || {o_y1, o_f1} !== o_e1) begin fails++; $display("FAIL rnd_sat1[%0d]: y=%0d flag=%b, want y=%0d flag=%b", i, o_y1, o_f1, o_e1.y, o_e1.f); end
            end
        end
        for (int i = 0; i < 20 && q0.size() > 0; i++) begin
            tick(0, 2'd0, 4'd0, 4'd0, 1);
            if (o_emit) begin
                tests++;
                if (o_qerr || {o_y0, o_f0} !== o_e0 || {o_y1, o_f1} !== o_e1)
                    begin fails++; $display("FAIL rnd_drain: y=%0d/%0d, want %0d/%0d", o_y0, o_y1, o_e0.y, o_e1.y); end
            end
        end
        tests++; if (q0.size() != 0 || out_valid0 !== 1'b0) begin fails++; $display("FAIL rnd_empty: pending=%0d out_valid=%b, want 0 0", q0.size(), out_valid0); end
        tests++;
        if (acc_ovf0 !== m_ovf[0] || acc_ovf1 !== m_ovf[1])
            begin fails++; $display("FAIL rnd_acc_ovf: %b/%b, want %b/%b", acc_ovf0, acc_ovf1, m_ovf[0], m_ovf[1]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_accumulate();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined adder/accumulator for the datapath test targets. It adds, subtracts, accumulates or loads operands. Results leave through a two-stage elastic pipeline with valid/ready handshakes on input and output, and the block reports a per-result carry/borrow/overflow flag plus a sticky accumulator-overflow flag. It is the drop-in successor to the single-cycle adder for benches that need backpressure and multi-cycle arithmetic.

## Interface
- WIDTH, 4: operand width in bits.
- ACC_EXT, 4: extra accumulator bits. ACC_W = WIDTH + ACC_EXT.
- SAT, 0: 1 = accumulator saturates at all-ones; 0 = accumulator wraps.
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand beat valid.
- in_ready  out  1: block accepts a beat this cycle.
- a, b  in  WIDTH each: unsigned operands.
- mode  in  2: 00 add, 01 sub, 10 accumulate, 11 load accumulator.
- out_valid  out  1: result beat valid.
- out_ready  in  1: consumer accepts the result.
- y  out  ACC_W: result.
- flag  out  1: carry (add), borrow (sub) or overflow (acc/load) for this result.
- acc_ovf  out  1: sticky accumulator overflow.

## Operation
- Accept: a beat is accepted on an edge where in_valid && in_ready. mode, a and b are sampled only at accept.
- Stage 1 computes and registers the result and its flag. Stage 2 is the output register (y, flag, out_valid).
- add: y = zero-extend(a + b), computed at WIDTH+1 bits; flag = bit WIDTH of that sum.
- sub: y = sign-extend the WIDTH+1-bit two's-complement value of a - b to ACC_W; flag = (a < b).
- load (11): acc <= zero-extend(a + b); y = the new acc; flag = 0; acc_ovf cleared.
- accumulate (10): next = acc + a + b, computed at ACC_W+1 bits.
  - If bit ACC_W of next is 1: flag = 1 and acc_ovf is set. acc <= all-ones when SAT=1, otherwise the low ACC_W bits.
  - Otherwise acc <= next; flag = 0.
  - y = the new acc.
- acc is internal and updates on the accept edge. Back-to-back acc/load beats therefore chain correctly without stalls.
- add and sub neither read nor modify acc.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset (async assert, sync release) forces: in_ready=1 after release, out_valid=0, y=0, flag=0, acc_ovf=0, acc=0, both stage valids=0. Reset mid-flight discards all in-flight beats.
- Latency: a beat accepted at edge N drives out_valid=1 with its y/flag from edge N+1. That is 2 cycles with out_ready held high.
- Throughput: 1 beat/cycle while out_ready=1.
- s2_adv = !out_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is a combinational path out_ready -> in_ready, and that path is allowed.
- Stall: with out_ready=0, the block holds at most 2 beats. in_ready drops once both stages are full. y and flag stay stable while out_valid && !out_ready.
- Simultaneous accept and emit on the same edge is legal and keeps full throughput.
- in_valid with in_ready=0: nothing is sampled and acc is unchanged.
- acc_ovf stays set until reset or a load beat is accepted.

## Test plan
- WIDTH=4, ACC_EXT=4, SAT=0, out_ready=1. Send add 9+8, then add 3+4 -> y=17 flag=1 at edge N+1, then y=7 flag=0 on the next cycle.
- sub 3-5, then sub 5-3 -> y=8'hFE flag=1, then y=2 flag=0.
- load 15+15, then seven accumulate 15+15 -> y = 30, 60, ..., 240, all flag=0. An eighth accumulate -> y=14, flag=1, acc_ovf=1. A following load 1+1 -> y=2, acc_ovf=0.
- Same sequence with SAT=1 -> eighth accumulate gives y=255, flag=1; a further accumulate stays y=255.
- Hold out_ready=0 and offer beats add 1+1, 2+2, 3+3 -> only two accepted, in_ready=0, y=2 stable. Release out_ready -> outputs 2, 4, 6 in order with no loss.
- Assert reset while two beats are buffered and acc=40 -> out_valid=0, y=0 and acc_ovf=0 immediately (asynchronously). After release, accumulate 1+1 -> y=2.
